alu_pipe: RTL

- Two-stage pipelined integer execution unit, directly downstream of the reservation station.
- Accepts one ready RV32I non-memory operation per cycle: arithmetic/logic, shift, compare, LUI/AUIPC, branch, JAL/JALR.
- Computes the register result and the next-PC / redirect information.
- Drives the ALU CDB broadcast consumed by the reservation station, LSB and ROB.

---
 rtl/alu_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage RV32I integer execution unit feeding the ALU CDB; issue-to-broadcast latency 2 cycles.
// No backpressure (1 op/cycle); rdy_in low freezes every register, roll_back flushes both stages.
module alu_pipe #(
  parameter int ENTRY_W = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               new_calculate,
  input  logic [5:0]         op_in,
  input  logic [31:0]        inst_in,
  input  logic [31:0]        vj_in,
  input  logic [31:0]        vk_in,
  input  logic [31:0]        imm_in,
  input  logic [31:0]        pc_in,
  input  logic [ENTRY_W-1:0] entry_in,
  output logic               alu_broadcast,
  output logic [ENTRY_W-1:0] alu_entry,
  output logic [31:0]        alu_value,
  output logic [31:0]        alu_pc_out,
  output logic               alu_jump
);

  localparam logic [ENTRY_W-1:0] ENTRY_NULL = '1;

  localparam logic [5:0] OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_AND  = 6'd3,  OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5,  OP_SLL  = 6'd6,  OP_SRL  = 6'd7,  OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SLT  = 6'd9,  OP_SLTU = 6'd10, OP_ADDI = 6'd11, OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13, OP_XORI = 6'd14, OP_SLLI = 6'd15, OP_SRLI = 6'd16;
  localparam logic [5:0] OP_SRAI = 6'd17, OP_SLTI = 6'd18, OP_SLTIU= 6'd19, OP_LUI  = 6'd20;
  localparam logic [5:0] OP_AUIPC= 6'd21, OP_JAL  = 6'd22, OP_JALR = 6'd23, OP_BEQ  = 6'd24;
  localparam logic [5:0] OP_BNE  = 6'd25, OP_BLT  = 6'd26, OP_BGE  = 6'd27, OP_BLTU = 6'd28;
  localparam logic [5:0] OP_BGEU = 6'd29;

  logic               a_valid;
  logic [5:0]         a_op;
  logic [31:0]        a_vj, a_vk, a_imm, a_pc;
  logic [ENTRY_W-1:0] a_entry;
  logic [31:0]        dbg_inst_unused;

  logic        use_imm;
  logic [31:0] opb, pc4, res, npc;
  logic [4:0]  shamt;
  logic        jmp;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_valid         <= 1'b0;
      a_op            <= '0;
      a_vj            <= '0;
      a_vk            <= '0;
      a_imm           <= '0;
      a_pc            <= '0;
      a_entry         <= '0;
      dbg_inst_unused <= '0;
    end else if (roll_back) begin
      a_valid <= 1'b0;
    end else if (rdy_in) begin
      a_valid         <= new_calculate;
      a_op            <= op_in;
      a_vj            <= vj_in;
      a_vk            <= vk_in;
      a_imm           <= imm_in;
      a_pc            <= pc_in;
      a_entry         <= entry_in;
      dbg_inst_unused <= inst_in;
    end
  end

  always_comb begin
    use_imm = (a_op >= OP_ADDI) && (a_op <= OP_SLTIU);
    opb     = use_imm ? a_imm : a_vk;
    shamt   = opb[4:0];
    pc4     = a_pc + 32'd4;
    res     = '0;
    npc     = pc4;
    jmp     = 1'b0;
    case (a_op)
      OP_ADD, OP_ADDI:   res = a_vj + opb;
      OP_SUB:            res = a_vj - a_vk;
      OP_AND, OP_ANDI:   res = a_vj & opb;
      OP_OR,  OP_ORI:    res = a_vj | opb;
      OP_XOR, OP_XORI:   res = a_vj ^ opb;
      OP_SLL, OP_SLLI:   res = a_vj << shamt;
      OP_SRL, OP_SRLI:   res = a_vj >> shamt;
      OP_SRA, OP_SRAI:   res = $unsigned($signed(a_vj) >>> shamt);
      OP_SLT, OP_SLTI:   res = {31'd0, $signed(a_vj) < $signed(opb)};
      OP_SLTU, OP_SLTIU: res = {31'd0, a_vj < opb};
      OP_LUI:            res = a_imm;
      OP_AUIPC:          res = a_pc + a_imm;
      OP_JAL: begin
        res = pc4;
        npc = a_pc + a_imm;
        jmp = 1'b1;
      end
      OP_JALR: begin
        res = pc4;
        npc = (a_vj + a_imm) & 32'hFFFF_FFFE;
        jmp = 1'b1;
      end
      OP_BEQ:  jmp = (a_vj == a_vk);
      OP_BNE:  jmp = (a_vj != a_vk);
      OP_BLT:  jmp = ($signed(a_vj) <  $signed(a_vk));
      OP_BGE:  jmp = ($signed(a_vj) >= $signed(a_vk));
      OP_BLTU: jmp = (a_vj <  a_vk);
      OP_BGEU: jmp = (a_vj >= a_vk);
      default: ;
    endcase
    // Branch target overrides the fall-through PC only when taken.
    if (jmp && (a_op >= OP_BEQ) && (a_op <= OP_BGEU)) npc = a_pc + a_imm;
  end

  // The broadcast register doubles as the stage-B valid bit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_broadcast <= 1'b0;
      alu_entry     <= ENTRY_NULL;
      alu_value     <= '0;
      alu_pc_out    <= '0;
      alu_jump      <= 1'b0;
    end else if (roll_back) begin
      alu_broadcast <= 1'b0;
      alu_entry     <= ENTRY_NULL;
    end else if (rdy_in) begin
      alu_broadcast <= a_valid;
      if (a_valid) begin
        alu_entry  <= a_entry;
        alu_value  <= res;
        alu_pc_out <= npc;
        alu_jump   <= jmp;
      end else begin
        alu_entry  <= ENTRY_NULL;
      end
    end
  end

endmodule
